ucode_seq: RTL and testbench

UCODE_SEQ -- requirements
Module: ucode_seq

---
 rtl/ucode_seq_if.sv | 52 +++++
 rtl/ucode_seq.sv | 193 +++++++++++++++++++
 tb/tb_ucode_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ucode_seq_if.sv
// ucode_seq_if -- signal bundle between a microcode sequencer and the
// rest of the core (control ROM, data bus, interrupt sources).
//
// Signals
//   rdy      1 = advance, 0 = stall
//   ucode    control word read from the synchronous ROM
//   DB       opcode from the data bus
//   cond     micro-branch condition
//   bank     bank select for sequencer-area targets
//   irq      level-sensitive interrupt request
//   I        interrupt mask
//   nmi      edge-triggered non-maskable interrupt
//   uaddr    next micro-address (to the ROM)
//   sync     opcode fetch in progress
//   we       registered write enable
//   irq_ack  one-cycle pulse when an IRQ vector is taken
//   nmi_ack  one-cycle pulse when an NMI vector is taken
//   fin_err  sticky finisher stack overflow/underflow flag
//
// Modports
//   master : core side; drives the inputs of the sequencer
//   slave  : the sequencer itself
interface ucode_seq_if #(
  parameter int AW  = 9,
  parameter int CW  = 31,
  parameter int OPW = 8
);
  logic           rdy;
  logic [CW-1:0]  ucode;
  logic [OPW-1:0] DB;
  logic           cond;
  logic           bank;
  logic           irq;
  logic           I;
  logic           nmi;
  logic [AW-1:0]  uaddr;
  logic           sync;
  logic           we;
  logic           irq_ack;
  logic           nmi_ack;
  logic           fin_err;

  modport master (
    output rdy, ucode, DB, cond, bank, irq, I, nmi,
    input  uaddr, sync, we, irq_ack, nmi_ack, fin_err
  );

  modport slave (
    input  rdy, ucode, DB, cond, bank, irq, I, nmi,
    output uaddr, sync, we, irq_ack, nmi_ack, fin_err
  );
endinterface

// File: rtl/ucode_seq.sv
// ucode_seq -- microcode sequencer.
//
// Computes the next micro-address every cycle from the current control
// word. The address space is split in two halves: the lower half holds one
// entry per opcode, the upper half holds sequencer code (with a selectable
// bank bit). A small LIFO "finisher" stack lets microcode call a shared
// tail and return to a per-call finisher routine at FIN_BASE | index.
//
// Ports
//   clk    clock, single domain
//   reset  synchronous, active-high reset
//   bus    ucode_seq_if.slave: rdy, ucode, DB, cond, bank, irq, I, nmi in;
//          uaddr (combinational), sync, we, irq_ack, nmi_ack, fin_err out
//
// Control-word fields: seq selects the sequencing op, nxt is the in-area
// target, fin is the index pushed by CALL, ucode[WE_BIT] is the write enable.
// OPW must equal AW-1 so that {1'b0, DB} spans the opcode area.
module ucode_seq #(
  parameter int            AW        = 9,
  parameter int            CW        = 31,
  parameter int            OPW       = 8,
  parameter int            FW        = 5,
  parameter int            FDEPTH    = 2,
  parameter int            NXT_LSB   = 0,
  parameter int            FIN_LSB   = 10,
  parameter int            SEQ_LSB   = 22,
  parameter int            WE_BIT    = 28,
  parameter logic [AW-1:0] RESET_VEC = 9'h160,
  parameter logic [AW-1:0] IRQ_VEC   = 9'h168,
  parameter logic [AW-1:0] NMI_VEC   = 9'h16C,
  parameter logic [AW-1:0] FIN_BASE  = 9'h140
) (
  input logic        clk,
  input logic        reset,
  ucode_seq_if.slave bus
);

  localparam logic [2:0] SEQ_DECODE = 3'b000;
  localparam logic [2:0] SEQ_NEXT   = 3'b001;
  localparam logic [2:0] SEQ_FINISH = 3'b010;
  localparam logic [2:0] SEQ_CALL   = 3'b011;
  localparam logic [2:0] SEQ_BRANCH = 3'b100;
  localparam logic [2:0] SEQ_WAIT   = 3'b101;

  // Stack pointer counts entries 0..FDEPTH; IW indexes the entry array.
  localparam int SPW = $clog2(FDEPTH + 1);
  localparam int IW  = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

  // Registers
  logic [AW-1:0]  r_cur;
  logic           r_we;
  logic           r_nmi_q;
  logic           r_nmi_pend;
  logic           r_fin_err;
  logic [SPW-1:0] r_sp;
  logic [FW-1:0]  r_stk [FDEPTH];

  // Decoded fields and next-state wires
  logic [2:0]     w_seq;
  logic [AW-3:0]  w_nxt;
  logic [FW-1:0]  w_fin;
  logic [AW-1:0]  w_s_tgt;
  logic [AW-2:0]  w_low_inc;
  logic [AW-1:0]  w_inc_tgt;
  logic           w_empty;
  logic           w_full;
  logic [IW-1:0]  w_top;
  logic [IW-1:0]  w_wr;
  logic [FW-1:0]  w_pop_idx;
  logic           w_nmi_edge;
  logic [AW-1:0]  w_next;
  logic           w_dec;
  logic           w_push;
  logic           w_pop;
  logic           w_clr;
  logic           w_take_nmi;
  logic           w_take_irq;
  logic           w_unused_ucode;

  assign w_seq = bus.ucode[SEQ_LSB +: 3];
  assign w_nxt = bus.ucode[NXT_LSB +: AW-2];
  assign w_fin = bus.ucode[FIN_LSB +: FW];
  // Only some control-word bits belong to the sequencer; the rest drive
  // the datapath elsewhere.
  assign w_unused_ucode = ^bus.ucode;

  assign w_s_tgt   = {1'b1, bus.bank, w_nxt};
  // Sequential fall-through stays inside the sequencer half.
  assign w_low_inc = r_cur[AW-2:0] + (AW-1)'(1);
  assign w_inc_tgt = {1'b1, w_low_inc};

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SPW'(FDEPTH));
  assign w_top     = IW'(r_sp - SPW'(1));
  assign w_wr      = IW'(r_sp);
  // Underflow returns to finisher 0.
  assign w_pop_idx = w_empty ? '0 : r_stk[w_top];

  assign w_nmi_edge = bus.nmi & ~r_nmi_q;

  always_comb begin
    w_next     = r_cur;
    w_dec      = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_clr      = 1'b0;
    w_take_nmi = 1'b0;
    w_take_irq = 1'b0;
    case (w_seq)
      SEQ_DECODE: w_dec = 1'b1;
      SEQ_NEXT:   w_next = w_s_tgt;
      SEQ_FINISH: begin
        w_pop  = 1'b1;
        w_next = FIN_BASE | AW'(w_pop_idx);
      end
      SEQ_CALL: begin
        w_push = 1'b1;
        w_next = w_s_tgt;
      end
      SEQ_BRANCH: w_next = bus.cond ? w_s_tgt : w_inc_tgt;
      // WAIT wakes on any irq regardless of I, then dispatches like DECODE
      // (where I does apply), so a masked irq falls through to the opcode.
      SEQ_WAIT: begin
        if (r_nmi_pend | bus.irq) w_dec = 1'b1;
      end
      default:    w_next = w_s_tgt;
    endcase
    if (w_dec) begin
      w_clr = 1'b1;
      if (r_nmi_pend) begin
        w_take_nmi = 1'b1;
        w_next     = NMI_VEC;
      end else if (bus.irq & ~bus.I) begin
        w_take_irq = 1'b1;
        w_next     = IRQ_VEC;
      end else begin
        w_next = {1'b0, bus.DB};
      end
    end
  end

  assign bus.uaddr   = reset ? RESET_VEC : (bus.rdy ? w_next : r_cur);
  assign bus.sync    = bus.rdy & (w_seq == SEQ_DECODE);
  assign bus.we      = r_we;
  assign bus.nmi_ack = ~reset & bus.rdy & w_take_nmi;
  assign bus.irq_ack = ~reset & bus.rdy & w_take_irq;
  assign bus.fin_err = r_fin_err;

  // Control state: address, write enable, NMI detection, stack pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur      <= RESET_VEC;
      r_we       <= 1'b0;
      r_nmi_q    <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_fin_err  <= 1'b0;
      r_sp       <= '0;
    end else begin
      // Edge detection keeps running through stalls.
      r_nmi_q <= bus.nmi;
      // A fresh edge beats the clear from taking the previous NMI.
      if (w_nmi_edge) r_nmi_pend <= 1'b1;
      else if (bus.rdy & w_take_nmi) r_nmi_pend <= 1'b0;

      if (bus.rdy) begin
        r_cur <= w_next;
        r_we  <= bus.ucode[WE_BIT];
        if (w_clr) begin
          r_sp <= '0;
        end else if (w_push) begin
          if (w_full) r_fin_err <= 1'b1;
          else        r_sp      <= r_sp + SPW'(1);
        end else if (w_pop) begin
          if (w_empty) r_fin_err <= 1'b1;
          else         r_sp      <= r_sp - SPW'(1);
        end
      end
    end
  end

  // Stack contents: on overflow the oldest entry shifts out at the bottom.
  always_ff @(posedge clk) begin
    if (~reset & bus.rdy & ~w_clr & w_push) begin
      if (w_full) begin
        for (int k = 0; k < FDEPTH - 1; k++) r_stk[k] <= r_stk[k+1];
        r_stk[FDEPTH-1] <= w_fin;
      end else begin
        r_stk[w_wr] <= w_fin;
      end
    end
  end

endmodule

// File: tb/tb_ucode_seq.sv
module tb_ucode_seq;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  localparam logic [2:0] DEC = 3'b000;
  localparam logic [2:0] NXT = 3'b001;
  localparam logic [2:0] FIN = 3'b010;
  localparam logic [2:0] CAL = 3'b011;
  localparam logic [2:0] BRA = 3'b100;
  localparam logic [2:0] WAI = 3'b101;
  localparam logic [2:0] RSV = 3'b110;

  ucode_seq_if #(.AW(9), .CW(31), .OPW(8)) bus ();

  ucode_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [30:0] uw(input logic [2:0] s, input logic [6:0] nx,
                                     input logic [4:0] f, input logic w);
    logic [30:0] v;
    v         = '0;
    v[0 +: 7] = nx;
    v[10 +: 5] = f;
    v[22 +: 3] = s;
    v[28]     = w;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to the drive point of the next cycle; outputs settle #1 later.
  task automatic nxt_cyc();
    @(negedge clk);
  endtask

  task automatic drv(input logic r, input logic [30:0] u);
    bus.rdy   = r;
    bus.ucode = u;
    #1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    reset = 1'b1;
    bus.rdy = 1'b1; bus.ucode = '0; bus.DB = '0; bus.cond = 1'b0;
    bus.bank = 1'b0; bus.irq = 1'b0; bus.I = 1'b0; bus.nmi = 1'b0;

    // Reset state
    nxt_cyc(); drv(1'b1, uw(NXT, 7'h2A, 5'h0, 1'b1));
    chk("rst_uaddr", 32'(bus.uaddr), 32'h160);
    chk("rst_nmi_ack", 32'(bus.nmi_ack), 0);
    nxt_cyc(); drv(1'b1, uw(DEC, 7'h00, 5'h0, 1'b1));
    chk("rst_we", 32'(bus.we), 0);
    chk("rst_fin_err", 32'(bus.fin_err), 0);

    // Decode path
    reset = 1'b0; bus.DB = 8'hA5; #1;
    chk("dec_uaddr", 32'(bus.uaddr), 32'h0A5);
    chk("dec_sync", 32'(bus.sync), 1);
    nxt_cyc(); bus.bank = 1'b0; drv(1'b1, uw(NXT, 7'h22, 5'h0, 1'b0));
    chk("we_load", 32'(bus.we), 1);
    chk("next_uaddr", 32'(bus.uaddr), 32'h122);
    chk("next_sync", 32'(bus.sync), 0);

    // CALL then FINISH
    nxt_cyc(); bus.bank = 1'b1; drv(1'b1, uw(CAL, 7'h10, 5'h03, 1'b0));
    chk("we_clear", 32'(bus.we), 0);
    chk("call_uaddr", 32'(bus.uaddr), 32'h190);
    nxt_cyc(); drv(1'b1, uw(FIN, 7'h00, 5'h00, 1'b0));
    chk("fin_uaddr", 32'(bus.uaddr), 32'h143);
    nxt_cyc(); bus.bank = 1'b0; bus.cond = 1'b1; drv(1'b1, uw(BRA, 7'h05, 5'h0, 1'b0));
    chk("fin_no_err", 32'(bus.fin_err), 0);
    chk("bra_taken", 32'(bus.uaddr), 32'h105);
    nxt_cyc(); bus.cond = 1'b0; drv(1'b1, uw(BRA, 7'h05, 5'h0, 1'b0));
    chk("bra_fall", 32'(bus.uaddr), 32'h106);
    nxt_cyc(); bus.bank = 1'b1; drv(1'b1, uw(RSV, 7'h7F, 5'h0, 1'b0));
    chk("rsv_as_next", 32'(bus.uaddr), 32'h1FF);
    nxt_cyc(); drv(1'b1, uw(BRA, 7'h05, 5'h0, 1'b0));
    chk("bra_wrap", 32'(bus.uaddr), 32'h100);

    // Stall during BRANCH
    nxt_cyc(); bus.bank = 1'b0; drv(1'b1, uw(NXT, 7'h30, 5'h0, 1'b1));
    chk("pre_stall", 32'(bus.uaddr), 32'h130);
    for (int i = 0; i < 3; i++) begin
      nxt_cyc(); bus.cond = ~i[0]; drv(1'b0, uw(BRA, 7'h11, 5'h0, 1'b0));
      chk("stall_uaddr", 32'(bus.uaddr), 32'h130);
      chk("stall_we", 32'(bus.we), 1);
    end
    nxt_cyc(); bus.cond = 1'b0; drv(1'b1, uw(BRA, 7'h11, 5'h0, 1'b0));
    chk("stall_resolve", 32'(bus.uaddr), 32'h131);
    chk("stall_we_held", 32'(bus.we), 1);

    // NMI over IRQ, edge two cycles before DECODE
    nxt_cyc(); bus.nmi = 1'b1; bus.irq = 1'b1; bus.I = 1'b0; drv(1'b1, uw(NXT, 7'h01, 5'h0, 1'b0));
    chk("we_after_stall", 32'(bus.we), 0);
    nxt_cyc(); drv(1'b1, uw(NXT, 7'h01, 5'h0, 1'b0));
    nxt_cyc(); drv(1'b1, uw(DEC, 7'h00, 5'h0, 1'b0));
    chk("nmi_uaddr", 32'(bus.uaddr), 32'h16C);
    chk("nmi_ack", 32'(bus.nmi_ack), 1);
    chk("nmi_no_irq_ack", 32'(bus.irq_ack), 0);
    nxt_cyc(); drv(1'b1, uw(DEC, 7'h00, 5'h0, 1'b0));
    chk("irq_uaddr", 32'(bus.uaddr), 32'h168);
    chk("irq_ack", 32'(bus.irq_ack), 1);
    chk("irq_no_nmi_ack", 32'(bus.nmi_ack), 0);
    nxt_cyc(); bus.I = 1'b1; bus.DB = 8'h3C; bus.nmi = 1'b0; drv(1'b1, uw(DEC, 7'h00, 5'h0, 1'b0));
    chk("irq_masked", 32'(bus.uaddr), 32'h03C);
    chk("masked_ack", 32'(bus.irq_ack), 0);

    // WAIT
    nxt_cyc(); bus.irq = 1'b0; drv(1'b1, uw(WAI, 7'h00, 5'h0, 1'b0));
    chk("wait_hold", 32'(bus.uaddr), 32'h03C);
    nxt_cyc(); bus.irq = 1'b1; bus.I = 1'b1; bus.DB = 8'h55; drv(1'b1, uw(WAI, 7'h00, 5'h0, 1'b0));
    chk("wait_wake", 32'(bus.uaddr), 32'h055);
    nxt_cyc(); bus.I = 1'b0; drv(1'b1, uw(WAI, 7'h00, 5'h0, 1'b0));
    chk("wait_irq", 32'(bus.uaddr), 32'h168);
    chk("wait_irq_ack", 32'(bus.irq_ack), 1);

    // New NMI edge in the cycle an NMI is taken keeps it pending
    nxt_cyc(); bus.irq = 1'b0; bus.nmi = 1'b1; drv(1'b1, uw(NXT, 7'h01, 5'h0, 1'b0));
    nxt_cyc(); bus.nmi = 1'b0; drv(1'b1, uw(NXT, 7'h01, 5'h0, 1'b0));
    nxt_cyc(); bus.nmi = 1'b1; drv(1'b1, uw(DEC, 7'h00, 5'h0, 1'b0));
    chk("nmi_a", 32'(bus.uaddr), 32'h16C);
    nxt_cyc(); drv(1'b1, uw(DEC, 7'h00, 5'h0, 1'b0));
    chk("nmi_set_wins", 32'(bus.uaddr), 32'h16C);
    chk("nmi_set_wins_ack", 32'(bus.nmi_ack), 1);
    nxt_cyc(); bus.DB = 8'h44; bus.nmi = 1'b0; drv(1'b1, uw(DEC, 7'h00, 5'h0, 1'b0));
    chk("nmi_cleared", 32'(bus.uaddr), 32'h044);

    // NMI edge captured while stalled
    nxt_cyc(); bus.nmi = 1'b1; drv(1'b0, uw(DEC, 7'h00, 5'h0, 1'b0));
    chk("stall_dec_uaddr", 32'(bus.uaddr), 32'h044);
    chk("stall_dec_ack", 32'(bus.nmi_ack), 0);
    chk("stall_dec_sync", 32'(bus.sync), 0);
    nxt_cyc(); drv(1'b1, uw(DEC, 7'h00, 5'h0, 1'b0));
    chk("stall_nmi", 32'(bus.uaddr), 32'h16C);
    chk("stall_nmi_ack", 32'(bus.nmi_ack), 1);

    // Reset during stall wins over rdy
    nxt_cyc(); bus.nmi = 1'b0; reset = 1'b1; drv(1'b0, uw(NXT, 7'h01, 5'h0, 1'b0));
    chk("rst_stall_uaddr", 32'(bus.uaddr), 32'h160);
    nxt_cyc(); reset = 1'b0; bus.cond = 1'b0; drv(1'b1, uw(BRA, 7'h01, 5'h0, 1'b0));
    chk("rst_stall_cur", 32'(bus.uaddr), 32'h161);

    // Stack bounds: three CALLs, three FINISHes
    nxt_cyc(); bus.bank = 1'b0; drv(1'b1, uw(CAL, 7'h00, 5'h11, 1'b0));
    nxt_cyc(); drv(1'b1, uw(CAL, 7'h00, 5'h12, 1'b0));
    nxt_cyc(); drv(1'b1, uw(CAL, 7'h00, 5'h13, 1'b0));
    chk("pre_ovf_err", 32'(bus.fin_err), 0);
    nxt_cyc(); drv(1'b1, uw(FIN, 7'h00, 5'h0, 1'b0));
    chk("ovf_err", 32'(bus.fin_err), 1);
    chk("pop_f3", 32'(bus.uaddr), 32'h153);
    nxt_cyc(); drv(1'b1, uw(FIN, 7'h00, 5'h0, 1'b0));
    chk("pop_f2", 32'(bus.uaddr), 32'h152);
    nxt_cyc(); drv(1'b1, uw(FIN, 7'h00, 5'h0, 1'b0));
    chk("pop_empty", 32'(bus.uaddr), 32'h140);
    nxt_cyc(); reset = 1'b1; drv(1'b1, uw(NXT, 7'h00, 5'h0, 1'b0));
    chk("bounds_err", 32'(bus.fin_err), 1);
    chk("bounds_rst_uaddr", 32'(bus.uaddr), 32'h160);
    nxt_cyc(); reset = 1'b0; drv(1'b1, uw(CAL, 7'h00, 5'h07, 1'b0));
    chk("rst_clears_err", 32'(bus.fin_err), 0);

    // DECODE empties the stack; the following FINISH underflows
    nxt_cyc(); bus.DB = 8'h12; drv(1'b1, uw(DEC, 7'h00, 5'h0, 1'b0));
    chk("clr_dec", 32'(bus.uaddr), 32'h012);
    nxt_cyc(); drv(1'b1, uw(FIN, 7'h00, 5'h0, 1'b0));
    chk("clr_pop", 32'(bus.uaddr), 32'h140);
    chk("clr_err_pre", 32'(bus.fin_err), 0);
    nxt_cyc(); drv(1'b1, uw(NXT, 7'h00, 5'h0, 1'b0));
    chk("unf_err", 32'(bus.fin_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
